// File: rtl/branch_resolve_sequencer.sv
// Ordered resolved-branch queue: merges two branch ports into one in-order
// stream for the frontend and suppresses wrong-path resolutions until a flush.

package branch_resolve_sequencer_pkg;
    localparam int unsigned VLEN = 64;

    typedef struct packed {
        logic [31:0] reserved;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target_address;
        logic            is_mispredict;
        logic            is_taken;
        logic [2:0]      cf_type;
    } bp_resolve_t;
endpackage

module branch_resolve_sequencer
    import branch_resolve_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  bp_resolve_t [1:0]          res_i,
    output logic                       ready_o,
    output bp_resolve_t                resolved_branch_o,
    output logic                       squash_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic                       overflow_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_e;

    state_e      state_q, state_d;
    bp_resolve_t mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q, wr1;
    logic [CW-1:0] count_q, free;
    logic          pop, v0, v1, push0, push1, drop;
    logic          overflow_q;
    logic          unused_cfg;

    assign unused_cfg = ^CVA6Cfg;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Next state plus push/drop decisions; space is counted after this cycle's pop
    always_comb begin
        state_d = state_q;
        v0      = 1'b0;
        v1      = 1'b0;
        push0   = 1'b0;
        push1   = 1'b0;
        drop    = 1'b0;
        pop     = (count_q != '0);
        free    = CW'(DEPTH) - count_q + CW'(pop);
        if (!flush_i && state_q == RUN) begin
            v0    = res_i[0].valid;
            v1    = res_i[1].valid && !(res_i[0].valid && res_i[0].is_mispredict);
            push0 = v0 && (free != '0);
            push1 = v1 && (free >= (push0 ? CW'(2) : CW'(1)));
            drop  = (v0 && !push0) || (v1 && !push1);
            if ((push0 && res_i[0].is_mispredict) || (push1 && res_i[1].is_mispredict))
                state_d = SQUASH;
        end
        if (flush_i) state_d = RUN;
    end

    assign wr1 = push0 ? PW'(wr_q + PW'(1)) : wr_q;

    // Pointers, count and sticky overflow
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_q + PW'(pop);
            wr_q    <= wr_q + PW'(push0) + PW'(push1);
            count_q <= count_q - CW'(pop) + CW'(push0) + CW'(push1);
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Payload storage; contents are only observed through the count-gated head
    always_ff @(posedge clk_i) begin
        if (push0) mem_q[wr_q] <= res_i[0];
        if (push1) mem_q[wr1]  <= res_i[1];
    end

    assign resolved_branch_o = pop ? mem_q[rd_q] : '0;
    assign ready_o           = (CW'(DEPTH) - count_q) >= CW'(2);
    assign squash_o          = (state_q == SQUASH);
    assign occupancy_o       = count_q;
    assign overflow_o        = overflow_q;

endmodule

// File: tb/tb_branch_resolve_sequencer.sv
// Directed bench for branch_resolve_sequencer (DEPTH = 4) with hand-computed
// expected head records, occupancy and status flags.

module tb_branch_resolve_sequencer;
    import branch_resolve_sequencer_pkg::*;

    logic              clk;
    logic              rst;
    logic              flush;
    bp_resolve_t [1:0] res;
    logic              ready;
    bp_resolve_t       rb;
    logic              squash;
    logic [2:0]        occ;
    logic              ovf;
    bp_resolve_t       empty_rec;

    int nvec;
    int nerr;

    branch_resolve_sequencer #(.DEPTH(4)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .res_i            (res),
        .ready_o          (ready),
        .resolved_branch_o(rb),
        .squash_o         (squash),
        .occupancy_o      (occ),
        .overflow_o       (ovf)
    );

    always #5 clk = ~clk;

    function automatic bp_resolve_t mk(input logic [63:0] pc, input logic [63:0] tgt,
                                       input logic mis, input logic taken);
        bp_resolve_t r;
        r                = '0;
        r.valid          = 1'b1;
        r.pc             = pc;
        r.target_address = tgt;
        r.is_mispredict  = mis;
        r.is_taken       = taken;
        r.cf_type        = 3'd1;
        return r;
    endfunction

    function automatic bp_resolve_t rec(input logic [63:0] pc);
        return mk(pc, pc + 64'h40, 1'b0, 1'b1);
    endfunction

    function automatic bp_resolve_t mrec(input logic [63:0] pc);
        return mk(pc, pc + 64'h80, 1'b1, 1'b0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        res   = '0;
        flush = 1'b0;
    endtask

    task automatic chk_head(input string tag, input bp_resolve_t exp);
        nvec++;
        assert (rb === exp) else begin
            nerr++;
            $error("FAIL %s: observed valid=%b pc=%h tgt=%h mis=%b taken=%b, expected valid=%b pc=%h tgt=%h mis=%b taken=%b",
                   tag, rb.valid, rb.pc, rb.target_address, rb.is_mispredict, rb.is_taken,
                   exp.valid, exp.pc, exp.target_address, exp.is_mispredict, exp.is_taken);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk_head({tag, "_rb"}, empty_rec);
        chk_val({tag, "_ready"}, 32'(ready), 32'd1);
        chk_val({tag, "_squash"}, 32'(squash), 32'd0);
        chk_val({tag, "_occ"}, 32'(occ), 32'd0);
        chk_val({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        nvec      = 0;
        nerr      = 0;
        empty_rec = '0;
        clk       = 1'b0;
        rst       = 1'b1;
        idle();

        // Reset values
        #3;
        chk_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single resolution, one-cycle latency
        res[0] = mk(64'h8000_0010, 64'h8000_0040, 1'b0, 1'b1);
        step();
        idle();
        chk_head("single_head", mk(64'h8000_0010, 64'h8000_0040, 1'b0, 1'b1));
        chk_val("single_occ1", 32'(occ), 32'd1);
        step();
        chk_head("single_gone", empty_rec);
        chk_val("single_occ0", 32'(occ), 32'd0);

        // Dual push ordering
        res[0] = rec(64'h100);
        res[1] = rec(64'h104);
        step();
        idle();
        chk_head("dual_first", rec(64'h100));
        chk_val("dual_occ2", 32'(occ), 32'd2);
        step();
        chk_head("dual_second", rec(64'h104));
        chk_val("dual_occ1", 32'(occ), 32'd1);
        step();
        chk_head("dual_empty", empty_rec);
        chk_val("dual_occ0", 32'(occ), 32'd0);

        // Same-cycle squash of port 1, later input discarded, flush resumes
        res[0] = mrec(64'h200);
        res[1] = rec(64'h204);
        step();
        idle();
        chk_head("sq_head", mrec(64'h200));
        chk_val("sq_occ1", 32'(occ), 32'd1);
        chk_val("sq_squash", 32'(squash), 32'd1);
        res[0] = rec(64'h300);
        step();
        idle();
        chk_head("sq_discard_head", empty_rec);
        chk_val("sq_discard_occ", 32'(occ), 32'd0);
        chk_val("sq_still", 32'(squash), 32'd1);
        flush = 1'b1;
        step();
        idle();
        chk_val("sq_flush_clear", 32'(squash), 32'd0);
        res[0] = rec(64'h400);
        step();
        idle();
        chk_head("sq_after_flush", rec(64'h400));
        step();

        // Invalid port 0 carrying a mispredict bit is ignored
        res[0].is_mispredict = 1'b1;
        res[1] = rec(64'hA00);
        step();
        idle();
        chk_head("inv_mis_head", rec(64'hA00));
        chk_val("inv_mis_squash", 32'(squash), 32'd0);
        step();

        // Flush wins over a simultaneous mispredict
        flush  = 1'b1;
        res[0] = mrec(64'hB00);
        step();
        idle();
        chk_val("flushmis_squash", 32'(squash), 32'd0);
        chk_val("flushmis_occ", 32'(occ), 32'd0);
        chk_head("flushmis_head", empty_rec);

        // Backpressure and overflow: four dual-push cycles into DEPTH=4
        res[0] = rec(64'h600); res[1] = rec(64'h604);
        step();
        chk_val("bp_occ2", 32'(occ), 32'd2);
        chk_val("bp_ready2", 32'(ready), 32'd1);
        res[0] = rec(64'h608); res[1] = rec(64'h60C);
        step();
        chk_val("bp_occ3", 32'(occ), 32'd3);
        chk_val("bp_ready3", 32'(ready), 32'd0);
        chk_head("bp_head3", rec(64'h604));
        res[0] = rec(64'h610); res[1] = rec(64'h614);
        step();
        chk_val("bp_occ4", 32'(occ), 32'd4);
        chk_val("bp_ovf_none", 32'(ovf), 32'd0);
        res[0] = rec(64'h618); res[1] = rec(64'h61C);
        step();
        idle();
        chk_val("bp_ovf_set", 32'(ovf), 32'd1);
        chk_val("bp_occ_full", 32'(occ), 32'd4);
        chk_head("bp_drain0", rec(64'h60C));
        step();
        chk_head("bp_drain1", rec(64'h610));
        step();
        chk_head("bp_drain2", rec(64'h614));
        step();
        chk_head("bp_drain3", rec(64'h618));
        step();
        chk_head("bp_drained", empty_rec);
        chk_val("bp_ovf_sticky", 32'(ovf), 32'd1);
        flush = 1'b1;
        step();
        idle();
        chk_val("bp_ovf_after_flush", 32'(ovf), 32'd1);

        // Pointer wrap: write pointer at 3, dual push splits across the wrap
        res[0] = rec(64'h700); res[1] = rec(64'h704);
        step();
        idle();
        res[0] = rec(64'h708);
        step();
        res[0] = rec(64'h500); res[1] = rec(64'h504);
        step();
        idle();
        chk_head("wrap_pre", rec(64'h708));
        chk_val("wrap_occ3", 32'(occ), 32'd3);
        step();
        chk_head("wrap_slot3", rec(64'h500));
        step();
        chk_head("wrap_slot0", rec(64'h504));
        step();
        chk_head("wrap_empty", empty_rec);

        // Reset mid-drain with three entries queued and SQUASH active
        res[0] = rec(64'h800); res[1] = rec(64'h804);
        step();
        res[0] = rec(64'h808); res[1] = rec(64'h80C);
        step();
        idle();
        res[0] = mrec(64'h810);
        step();
        idle();
        chk_val("rst_pre_occ", 32'(occ), 32'd3);
        chk_val("rst_pre_squash", 32'(squash), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_state("rst_async");
        #2;
        rst    = 1'b0;
        res[0] = rec(64'h900);
        step();
        idle();
        chk_head("rst_post_head", rec(64'h900));
        chk_val("rst_post_occ", 32'(occ), 32'd1);
        step();
        chk_head("rst_post_empty", empty_rec);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
